// File: rtl/opp_channel_scheduler.sv
// Shares one output preprocessor between N_CH PID channels. Each channel's latest sample
// is latched, channels are served round-robin, and each result is returned with its channel tag.
module opp_channel_scheduler #(
  parameter int N_CH    = 4,
  parameter int W_CH    = 2,
  parameter int W_IN    = 64,
  parameter int W_OUT   = 16,
  parameter int TIMEOUT = 16
) (
  input  logic                 clk_in,
  input  logic                 reset_in,
  input  logic [N_CH*W_IN-1:0] pid_sum_in,
  input  logic [N_CH-1:0]      data_valid_in,
  input  logic [N_CH-1:0]      lock_en_in,
  input  logic                 overrun_clr_in,
  output logic [W_IN-1:0]      opp_pid_sum_out,
  output logic                 opp_data_valid_out,
  output logic                 opp_lock_en_out,
  input  logic [W_OUT-1:0]     opp_data_in,
  input  logic                 opp_data_valid_in,
  output logic [W_OUT-1:0]     data_out,
  output logic [W_CH-1:0]      chan_out,
  output logic                 data_valid_out,
  output logic [N_CH-1:0]      overrun_out,
  output logic                 timeout_out
);

  localparam int W_CNT = $clog2(TIMEOUT);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_SEND} state_t;

  state_t           r_state;
  state_t           w_stateNext;
  logic [N_CH-1:0]  r_pend;
  logic [N_CH-1:0]  r_holdLock;
  logic [N_CH-1:0]  r_overrun;
  logic [W_IN-1:0]  r_holdSum [N_CH];
  logic [W_CH-1:0]  r_sel;
  logic [W_CH-1:0]  r_rrPtr;
  logic [W_CH-1:0]  r_chan;
  logic [W_CNT-1:0] r_cnt;
  logic [W_IN-1:0]  r_oppSum;
  logic             r_oppLock;
  logic [W_OUT-1:0] r_result;

  logic             w_issue;
  logic             w_found;
  logic [W_CH-1:0]  w_pick;
  int               w_idx;
  logic [N_CH-1:0]  w_issueClr;
  logic [N_CH-1:0]  w_ovrSet;
  logic             w_timeout;
  logic [W_CH-1:0]  w_selNext;

  assign w_issue    = (r_state == ST_ISSUE);
  assign w_issueClr = w_issue ? (N_CH'(1) << r_sel) : '0;
  // A fresh sample landing in its own issue cycle replaces the issued one without an overrun.
  assign w_ovrSet   = data_valid_in & r_pend & ~w_issueClr;
  assign w_timeout  = (r_state == ST_WAIT) && !opp_data_valid_in &&
                      (r_cnt == W_CNT'(TIMEOUT - 1));
  assign w_selNext  = (r_sel == W_CH'(N_CH - 1)) ? '0 : r_sel + 1'b1;

  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = 0;
    for (int k = 0; k < N_CH; k++) begin
      w_idx = (int'(r_rrPtr) + k) % N_CH;
      if (!w_found && r_pend[w_idx]) begin
        w_found = 1'b1;
        w_pick  = W_CH'(w_idx);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_pend     <= '0;
      r_holdLock <= '0;
      r_overrun  <= '0;
      for (int i = 0; i < N_CH; i++) r_holdSum[i] <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (data_valid_in[i]) begin
          r_holdSum[i]  <= pid_sum_in[i*W_IN +: W_IN];
          r_holdLock[i] <= lock_en_in[i];
          r_pend[i]     <= 1'b1;
        end else if (w_issueClr[i]) begin
          r_pend[i] <= 1'b0;
        end
      end
      r_overrun <= (overrun_clr_in ? '0 : r_overrun) | w_ovrSet;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      ST_IDLE:  if (w_found) w_stateNext = ST_ISSUE;
      ST_ISSUE: w_stateNext = ST_WAIT;
      ST_WAIT: begin
        if (opp_data_valid_in) w_stateNext = ST_SEND;
        else if (w_timeout)    w_stateNext = ST_IDLE;
      end
      ST_SEND:  w_stateNext = ST_IDLE;
      default:  w_stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_sel     <= '0;
      r_rrPtr   <= '0;
      r_oppSum  <= '0;
      r_oppLock <= 1'b0;
      r_result  <= '0;
      r_chan    <= '0;
    end else begin
      r_state <= w_stateNext;
      if (w_stateNext != r_state)  r_cnt <= '0;
      else if (r_state == ST_WAIT) r_cnt <= r_cnt + 1'b1;
      if (r_state == ST_IDLE && w_found) r_sel <= w_pick;
      if (r_state == ST_SEND || w_timeout) r_rrPtr <= w_selNext;
      if (w_issue) begin
        r_oppSum  <= r_holdSum[r_sel];
        r_oppLock <= r_holdLock[r_sel];
      end
      if (r_state == ST_WAIT && opp_data_valid_in) begin
        r_result <= opp_data_in;
        r_chan   <= r_sel;
      end
    end
  end

  assign opp_data_valid_out = w_issue;
  assign opp_pid_sum_out    = w_issue ? r_holdSum[r_sel] : r_oppSum;
  assign opp_lock_en_out    = w_issue ? r_holdLock[r_sel] : r_oppLock;
  assign data_out           = r_result;
  assign chan_out           = r_chan;
  assign data_valid_out     = (r_state == ST_SEND);
  assign overrun_out        = r_overrun;
  assign timeout_out        = w_timeout;

endmodule
